// File: rtl/surf_axil_pkg.sv
// Shared constants and types for the surf_axil_regfile block: register
// indices, CTRL/STATUS bit positions, AXI response codes and FSM states.
package surf_axil_pkg;

    // Word indices of the fixed-function registers
    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bit positions
    localparam int STAT_READY_BIT = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Read channel FSM
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/surf_axil_regfile_if.sv
// AXI4-Lite bus bundle for surf_axil_regfile. The slave modport is the
// register file's view; the master modport is the view of whoever drives it.
interface surf_axil_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/surf_axil_wstrb_merge.sv
// Byte-lane merge for the register write path: each lane takes the new
// byte when its strobe is set and keeps the old byte otherwise.
module surf_axil_wstrb_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_data,
    input  logic [DW-1:0]   new_data,
    input  logic [DW/8-1:0] strb,
    output logic [DW-1:0]   merged
);

    // Select old or new byte per lane
    always_comb begin
        // NOTE: default assignment first so every path drives merged; no latch is inferred.
        merged = old_data;
        for (int b = 0; b < DW / 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/surf_axil_regfile.sv
// AXI4-Lite register file: reg0 CTRL (self-clearing start), reg1 STATUS
// (live ready, sticky done/start_err, W1C), reg2.. general read/write.
// Independent read and write FSMs, one outstanding transaction each.
// Optional macro SURF_AXIL_IRQ_EN adds CTRL.irq_en and an irq output.
module surf_axil_regfile
    import surf_axil_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 7,
    parameter int NUM_REGS             = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    surf_axil_regfile_if.slave                   s00_axi,
    input  logic                                 ip_ready,
    input  logic                                 ip_done,
    output logic                                 ip_start,
    output logic [NUM_REGS*C_S00_AXI_DATA_WIDTH-1:0] cfg_regs
`ifdef SURF_AXIL_IRQ_EN
    ,
    output logic                                 irq
`endif
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;
    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

    wr_state_e        w_state;
    rd_state_e        r_state;
    logic             bvalid_q;
    logic [1:0]       bresp_q;
    logic             rvalid_q;
    logic [1:0]       rresp_q;
    logic [DW-1:0]    rdata_q;

    logic [DW-1:0]    regs [2:NUM_REGS-1];
    logic             done_q;
    logic             err_q;
`ifdef SURF_AXIL_IRQ_EN
    logic             irq_en_q;
`endif

    logic [DW-1:0]    ctrl_view;
    logic [DW-1:0]    status_view;
    logic [DW-1:0]    view [NUM_REGS];

    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    ar_idx;
    logic             w_hit;
    logic             ar_hit;
    logic [DW-1:0]    w_old;
    logic [DW-1:0]    w_merged;
    logic [DW-1:0]    rd_word;
    logic             wr_en;
    logic             ctrl_wr;
    logic             status_wr;
    logic             start_req;
    logic             set_err;
    logic             clr_done;
    logic             clr_err;
    logic             unused_addr_bits;

    assign w_idx  = s00_axi.awaddr[AW-1:2];
    assign ar_idx = s00_axi.araddr[AW-1:2];
    assign w_hit  = (32'(w_idx) < NUM_REGS_U);
    assign ar_hit = (32'(ar_idx) < NUM_REGS_U);

    // Byte offset within a word is not used for register selection
    assign unused_addr_bits = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign s00_axi.awready = (w_state == W_ACK);
    assign s00_axi.wready  = (w_state == W_ACK);
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = (r_state == R_ACK);
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    // Software-visible images of CTRL and STATUS; start bit always reads 0
    always_comb begin
        ctrl_view   = '0;
        status_view = '0;
`ifdef SURF_AXIL_IRQ_EN
        ctrl_view[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
        status_view[STAT_READY_BIT] = ip_ready;
        status_view[STAT_DONE_BIT]  = done_q;
        status_view[STAT_ERR_BIT]   = err_q;
    end

    // Unified register view feeding reads, write merges and cfg_regs
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
        if (g == CTRL_IDX) begin : g_ctrl
            assign view[g] = ctrl_view;
        end else if (g == STATUS_IDX) begin : g_status
            assign view[g] = status_view;
        end else begin : g_gp
            assign view[g] = regs[g];
        end
        assign cfg_regs[g*DW +: DW] = view[g];
    end

    // Address decode: current value of the write target and the read target
    always_comb begin
        w_old   = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IW'(i)) begin
                w_old = view[i];
            end
            if (ar_idx == IW'(i)) begin
                rd_word = view[i];
            end
        end
    end

    surf_axil_wstrb_merge #(
        .DW (DW)
    ) u_merge (
        .old_data (w_old),
        .new_data (s00_axi.wdata),
        .strb     (s00_axi.wstrb),
        .merged   (w_merged)
    );

    assign wr_en     = (w_state == W_ACK) && w_hit;
    assign ctrl_wr   = wr_en && (w_idx == IW'(CTRL_IDX));
    assign status_wr = wr_en && (w_idx == IW'(STATUS_IDX));
    assign start_req = ctrl_wr && w_merged[CTRL_START_BIT];
    assign set_err   = start_req && !ip_ready;
    assign clr_done  = status_wr && s00_axi.wstrb[0] && s00_axi.wdata[STAT_DONE_BIT];
    assign clr_err   = status_wr && s00_axi.wstrb[0] && s00_axi.wdata[STAT_ERR_BIT];

    // Write channel: accept address+data together, commit, then respond
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (rst) begin
            w_state  <= W_IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s00_axi.awvalid && s00_axi.wvalid) begin
                        w_state <= W_ACK;
                    end
                end
                W_ACK: begin
                    w_state  <= W_RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= w_hit ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (s00_axi.bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Register storage, sticky status bits and the start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole register array is reset so software sees a defined image after rst.
            for (int i = 2; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ip_start <= 1'b0;
`ifdef SURF_AXIL_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else begin
            ip_start <= start_req && ip_ready;
            // Set terms are OR'd after the clear so a coincident set wins
            done_q   <= ip_done || (done_q && !clr_done);
            err_q    <= set_err || (err_q && !clr_err);
            if (wr_en) begin
                for (int i = 2; i < NUM_REGS; i++) begin
                    if (w_idx == IW'(i)) begin
                        regs[i] <= w_merged;
                    end
                end
            end
`ifdef SURF_AXIL_IRQ_EN
            if (ctrl_wr) begin
                irq_en_q <= w_merged[CTRL_IRQ_EN_BIT];
            end
`endif
        end
    end

`ifdef SURF_AXIL_IRQ_EN
    // Interrupt: sticky done gated by irq_en, registered
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= done_q && irq_en_q;
        end
    end
`endif

    // Read channel: accept address, register data, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s00_axi.arvalid) begin
                        r_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    r_state  <= R_DATA;
                    rvalid_q <= 1'b1;
                    rresp_q  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                    rdata_q  <= ar_hit ? rd_word : '0;
                end
                R_DATA: begin
                    if (s00_axi.rready) begin
                        rvalid_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_surf_axil_regfile.sv
// Self-checking bench for surf_axil_regfile (default build, macro
// SURF_AXIL_IRQ_EN undefined): directed vector table, hand sequences for
// start/done/W1C/concurrency/stall/reset, then random traffic against a
// behavioural register model.
module tb_surf_axil_regfile;
    import surf_axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;
    logic ip_ready;
    logic ip_done;
    logic ip_start;
    logic [NR*DW-1:0] cfg_regs;
`ifdef SURF_AXIL_IRQ_EN
    logic irq;
`endif

    always #5 clk = ~clk;

    surf_axil_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    surf_axil_regfile #(
        .C_S00_AXI_DATA_WIDTH (DW),
        .C_S00_AXI_ADDR_WIDTH (AW),
        .NUM_REGS             (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s00_axi  (axi),
        .ip_ready (ip_ready),
        .ip_done  (ip_done),
        .ip_start (ip_start),
        .cfg_regs (cfg_regs)
`ifdef SURF_AXIL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [NR];
    bit            m_done;
    bit            m_err;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        m_done = 0;
        m_err  = 0;
    endtask

    function automatic logic [DW-1:0] m_read(input int idx, input bit rdy);
        if (idx >= NR || idx == 0) return '0;
        if (idx == 1) return {29'd0, m_err, m_done, rdy};
        return m_mem[idx];
    endfunction

    function automatic logic [1:0] m_resp(input int idx);
        return (idx < NR) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb,
                           input bit rdy, output bit exp_start);
        exp_start = 0;
        if (idx >= NR) return;
        if (idx == 0) begin
            if (strb[0] && data[0]) begin
                if (rdy) exp_start = 1;
                else     m_err = 1;
            end
        end else if (idx == 1) begin
            if (strb[0] && data[1]) m_done = 0;
            if (strb[0] && data[2]) m_err  = 0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic start_at, output logic start_after);
        int t;
        resp = 'x; start_at = 'x; start_after = 'x;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.awready && t < 20);
        if (!axi.awready) begin
            check("aw_timeout", axi.awready, 1);
            axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0;
            return;
        end
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
        start_at = ip_start;
        t = 0;
        while (!axi.bvalid && t < 20) begin @(posedge clk); #1; t++; end
        if (!axi.bvalid) begin
            check("b_timeout", axi.bvalid, 1);
            axi.bready = 0;
            return;
        end
        resp = axi.bresp;
        @(posedge clk); #1;
        start_after = ip_start;
        axi.bready = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        int t;
        data = 'x; resp = 'x;
        axi.araddr = addr; axi.arvalid = 1; axi.rready = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.arready && t < 20);
        if (!axi.arready) begin
            check("ar_timeout", axi.arready, 1);
            axi.arvalid = 0; axi.rready = 0;
            return;
        end
        @(posedge clk); #1;
        axi.arvalid = 0;
        t = 0;
        while (!axi.rvalid && t < 20) begin @(posedge clk); #1; t++; end
        if (!axi.rvalid) begin
            check("r_timeout", axi.rvalid, 1);
            axi.rready = 0;
            return;
        end
        data = axi.rdata; resp = axi.rresp;
        @(posedge clk); #1;
        axi.rready = 0;
    endtask

    // Write whose response is left pending (bready low)
    task automatic wr_hold(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int t;
        axi.bready = 0;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.awready && t < 20);
        check("hold_aw", axi.awready, 1);
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
    endtask

    // Read whose data is left pending (rready low)
    task automatic rd_hold(input logic [AW-1:0] addr);
        int t;
        axi.rready = 0;
        axi.araddr = addr; axi.arvalid = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.arready && t < 20);
        check("hold_ar", axi.arready, 1);
        @(posedge clk); #1;
        axi.arvalid = 0;
    endtask

    typedef struct {
        bit              wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [3:0]      strb;
        logic [DW-1:0]   exp_rdata;
        logic [1:0]      exp_resp;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs [17];
        logic [1:0]    resp;
        logic [DW-1:0] rd;
        logic          s_at, s_after;
        bit            exp_start;
        int            bad, t;

        vecs[0]  = '{1'b1, 7'h08, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 7'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 7'h0C, 32'h11223344, 4'hF, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 7'h0C, 32'h000000AA, 4'h1, 32'h0,        2'b00};
        vecs[4]  = '{1'b0, 7'h0C, 32'h0,        4'h0, 32'h112233AA, 2'b00};
        vecs[5]  = '{1'b1, 7'h0F, 32'hCC000000, 4'h8, 32'h0,        2'b00};
        vecs[6]  = '{1'b0, 7'h0D, 32'h0,        4'h0, 32'hCC2233AA, 2'b00};
        vecs[7]  = '{1'b1, 7'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        vecs[8]  = '{1'b0, 7'h40, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[9]  = '{1'b1, 7'h48, 32'h12345678, 4'hF, 32'h0,        2'b10};
        vecs[10] = '{1'b0, 7'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[11] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[12] = '{1'b0, 7'h3C, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[13] = '{1'b1, 7'h3C, 32'hA5A5A5A5, 4'h6, 32'h0,        2'b00};
        vecs[14] = '{1'b0, 7'h3C, 32'h0,        4'h0, 32'h00A5A500, 2'b00};
        vecs[15] = '{1'b0, 7'h7C, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[16] = '{1'b0, 7'h04, 32'h0,        4'h0, 32'h1,        2'b00};

        // ---------------- reset ----------------
        rst = 1; ip_ready = 0; ip_done = 0;
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", axi.awready, 0);
        check("rst_arready", axi.arready, 0);
        check("rst_bvalid",  axi.bvalid, 0);
        check("rst_rvalid",  axi.rvalid, 0);
        check("rst_rdata",   axi.rdata, 0);
        check("rst_ip_start", ip_start, 0);
        check("rst_cfg_lo",  cfg_regs[63:0], 0);
        check("rst_cfg_hi",  cfg_regs[NR*DW-1 -: 64], 0);
        rst = 0;
        ip_ready = 1;
        @(posedge clk); #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, s_at, s_after);
                m_write(int'(vecs[i].addr[AW-1:2]), vecs[i].data, vecs[i].strb, ip_ready, exp_start);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end
        check("cfg_reg2", cfg_regs[2*DW +: DW], 32'hDEADBEEF);
        check("cfg_reg15", cfg_regs[15*DW +: DW], 32'h00A5A500);

        // ---------------- start pulse ----------------
        check("start_idle", ip_start, 0);
        axi_write(7'h00, 32'h1, 4'hF, resp, s_at, s_after);
        check("start_pulse", s_at, 1);
        check("start_one_cycle", s_after, 0);
        ip_ready = 1;
        axi_write(7'h00, 32'h1, 4'hE, resp, s_at, s_after);
        check("start_lane_off", s_at, 0);
        ip_ready = 0;
        axi_write(7'h00, 32'h1, 4'hF, resp, s_at, s_after);
        m_err = 1;
        check("start_suppressed", s_at, 0);
        axi_read(7'h04, rd, resp);
        check("status_err", rd, 32'h4);

        // ---------------- done sticky / W1C ----------------
        ip_ready = 1;
        axi_write(7'h04, 32'h4, 4'hF, resp, s_at, s_after);
        m_err = 0;
        axi_read(7'h04, rd, resp);
        check("status_err_clr", rd, 32'h1);
        ip_done = 1; @(posedge clk); #1; ip_done = 0;
        m_done = 1;
        axi_read(7'h04, rd, resp);
        check("status_done", rd, 32'h3);
        // W1C of done on the same edge as a new ip_done
        axi.awaddr = 7'h04; axi.wdata = 32'h2; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.awready && t < 20);
        check("w1c_race_aw", axi.awready, 1);
        ip_done = 1;
        @(posedge clk); #1;
        ip_done = 0; axi.awvalid = 0; axi.wvalid = 0;
        @(posedge clk); #1;
        axi.bready = 0;
        axi_read(7'h04, rd, resp);
        check("done_set_wins", rd, 32'h3);
        axi_write(7'h04, 32'h2, 4'hF, resp, s_at, s_after);
        m_done = 0;
        axi_read(7'h04, rd, resp);
        check("done_w1c", rd, 32'h1);

        // ---------------- concurrent read and write, same register ----------------
        axi_write(7'h10, 32'h0BADF00D, 4'hF, resp, s_at, s_after);
        axi.awaddr = 7'h10; axi.wdata = 32'h600DCAFE; axi.wstrb = 4'hF;
        axi.araddr = 7'h10;
        axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
        axi.bready = 1; axi.rready = 1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!axi.awready && t < 20);
        check("conc_same_cycle", {axi.awready, axi.arready}, 2'b11);
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
        check("conc_bvalid", axi.bvalid, 1);
        check("conc_rvalid", axi.rvalid, 1);
        check("conc_pre_write", axi.rdata, 32'h0BADF00D);
        @(posedge clk); #1;
        axi.bready = 0; axi.rready = 0;
        m_mem[4] = 32'h600DCAFE;
        axi_read(7'h10, rd, resp);
        check("conc_post_write", rd, 32'h600DCAFE);

        // ---------------- back-pressure ----------------
        wr_hold(7'h14, 32'h13579BDF);
        m_mem[5] = 32'h13579BDF;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) bad++;
        end
        check("b_stall_stable", bad, 0);
        axi.bready = 1; @(posedge clk); #1; axi.bready = 0;
        check("b_release", axi.bvalid, 0);
        rd_hold(7'h14);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h13579BDF) bad++;
        end
        check("r_stall_stable", bad, 0);
        axi.rready = 1; @(posedge clk); #1; axi.rready = 0;
        check("r_release", axi.rvalid, 0);

        // ---------------- reset mid-transaction ----------------
        wr_hold(7'h18, 32'hFEEDFACE);
        rd_hold(7'h18);
        check("pre_rst_bvalid", axi.bvalid, 1);
        rst = 1;
        @(posedge clk); #1;
        check("rst_mid_bvalid", axi.bvalid, 0);
        check("rst_mid_rvalid", axi.rvalid, 0);
        check("rst_mid_rdata", axi.rdata, 0);
        rst = 0;
        m_reset();
        @(posedge clk); #1;
        axi_read(7'h18, rd, resp);
        check("rst_cleared_reg6", rd, 32'h0);
        axi_read(7'h14, rd, resp);
        check("rst_cleared_reg5", rd, 32'h0);

        // ---------------- random traffic vs model ----------------
        for (int n = 0; n < 300; n++) begin
            int            idx;
            logic [AW-1:0] addr;
            logic [DW-1:0] data;
            logic [3:0]    strb;
            ip_ready = 1'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, NR + 3));
            addr = AW'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                if ($urandom_range(0, 3) == 0) data[0] = 1'b1;
                strb = 4'($urandom_range(0, 15));
                m_write(idx, data, strb, ip_ready, exp_start);
                axi_write(addr, data, strb, resp, s_at, s_after);
                check($sformatf("rnd%0d_bresp", n), resp, m_resp(idx));
                check($sformatf("rnd%0d_start", n), {s_at, s_after}, {exp_start, 1'b0});
            end else begin
                axi_read(addr, rd, resp);
                check($sformatf("rnd%0d_rresp", n), resp, m_resp(idx));
                check($sformatf("rnd%0d_rdata", n), rd, m_read(idx, ip_ready));
            end
        end
        for (int i = 0; i < NR; i++) begin
            check($sformatf("final_cfg%0d", i), cfg_regs[i*DW +: DW], m_read(i, ip_ready));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/surf_axil_regfile.md
SURF_AXIL_REGFILE -- requirements
Module: surf_axil_regfile

Interface
REQ-001 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32, AXI-Lite data width (multiple of 8).
REQ-002 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 7, byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, word register count (3..2^(C_S00_AXI_ADDR_WIDTH-2)).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s00_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, standard directions and widths.
- ip_ready  in  1  core idle.
- ip_done  in  1  one-cycle completion pulse.
- ip_start  out  1  one-cycle start pulse.
- cfg_regs  out  NUM_REGS*DATA_WIDTH  flat register image, reg0 at LSB.

Function
REQ-005 SHALL map word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; reg0 CTRL, reg1 STATUS, reg2..NUM_REGS-1 general RW.
REQ-006 Write FSM SHALL have states W_IDLE, W_ACK, W_RESP.
- W_IDLE -> W_ACK when awvalid and wvalid both high.
- In W_ACK, awready = wready = 1 for exactly one cycle and the write commits on that edge.
- W_ACK -> W_RESP; bvalid holds until bready, then -> W_IDLE.
REQ-007 Read FSM SHALL have states R_IDLE, R_ACK, R_DATA.
- arready = 1 for one cycle in R_ACK, and rdata is registered on that edge.
- rvalid holds with stable rdata until rready, then -> R_IDLE.
REQ-008 Writes SHALL honour wstrb per byte lane; lanes with strobe 0 keep their old value.
REQ-009 Index >= NUM_REGS SHALL respond SLVERR (2'b10): writes are discarded, reads return 0. Other accesses respond OKAY.
REQ-010 CTRL bit0 SHALL be self-clearing: a write of 1 with ip_ready=1 produces ip_start high for exactly the cycle after commit. CTRL always reads 0 in bit0.
REQ-011 A start write with ip_ready=0 SHALL suppress ip_start and set STATUS bit2 (start_err, sticky).
REQ-012 STATUS SHALL read as follows:
- bit0 = live ip_ready.
- bit1 = done sticky, set by ip_done.
- bit2 = start_err.
- bits1-2 are write-1-to-clear; other bits read 0 and ignore writes.
REQ-013 When ip_done and a W1C of bit1 occur on the same edge, set SHALL win.
REQ-014 When a read and a write to the same register complete on the same edge, the read SHALL return the pre-write value.
REQ-015 Read and write channels SHALL operate concurrently and independently; maximum one outstanding transaction per channel.

Reset
REQ-016 On rst, all registers, sticky bits, ip_start, awready, wready, bvalid, arready and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; both FSMs return to IDLE.
REQ-017 Reset mid-transaction SHALL abandon the transaction without issuing a response.

Configuration
REQ-018 Macro SURF_AXIL_IRQ_EN defined: the block SHALL add port irq (out, 1) and CTRL bit1 irq_en (RW). irq = STATUS.bit1 AND irq_en, registered, reset 0.
REQ-019 Macro SURF_AXIL_IRQ_EN undefined: there SHALL be no irq port, and CTRL bit1 reads 0.

Structure
REQ-020 Package surf_axil_pkg SHALL hold the register index constants, STATUS/CTRL bit positions, the OKAY/SLVERR codes, and the write/read FSM state enums.
REQ-021 Sub-module surf_axil_wstrb_merge (combinational old/new byte merge) SHALL be instantiated for the write path; all other logic stays in surf_axil_regfile.

Verification
REQ-022 Write 0xDEADBEEF to 0x08, wstrb 4'b1111, then read 0x08 -> rdata 0xDEADBEEF, OKAY both.
REQ-023 Write 0x000000AA to 0x0C with wstrb 4'b0001 over 0x11223344 -> readback 0x112233AA.
REQ-024 ip_ready=1, write 0x1 to 0x00 -> ip_start high exactly one cycle. ip_ready=0, same write -> no pulse, STATUS reads 0x4.
REQ-025 ip_done pulse, then read 0x04 -> 0x3 (ready=1). Write 0x2 to 0x04 on the same edge as a second ip_done -> bit1 stays 1.
REQ-026 Write/read to index NUM_REGS (0x40 at defaults) -> bresp/rresp 2'b10, rdata 0, no register changes.
REQ-027 bready/rready held low 10 cycles -> bvalid/rvalid and rdata stable. rst asserted mid-W_RESP -> bvalid 0 next cycle.
